divisor_secuencial: RTL

Iterative unsigned divider for the execute stage. It computes quotient and remainder one bit per cycle with a start/busy/done handshake, so the pipeline stalls on divide instead of carrying a full combinational divider in the critical path. Results and NZCV flags go to the ALU result mux and the flags register, in the same bit order as the rest of the ALU.

---
 rtl/divisor_secuencial.sv | 87 ++++++++
 1 files changed

// File: rtl/divisor_secuencial.sv
// divisor_secuencial: iterative restoring unsigned divider, one quotient bit per cycle, with NZCV flags.
module divisor_secuencial #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         cancel,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic [3:0]   banderas
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam int CW = $clog2(N + 1);
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [N-1:0]  dvd, dvs, r, r_nx, q_nx;
  logic [N:0]    rs, diff;
  logic          ge, accept, last;
  // The shifted remainder needs N+1 bits: r can exceed 2^(N-1) when b is large.
  always_comb begin
    rs     = {r, dvd[N-1]};
    diff   = rs - {1'b0, dvs};
    ge     = !diff[N];
    r_nx   = ge ? diff[N-1:0] : rs[N-1:0];
    q_nx   = {dvd[N-2:0], ge};
    accept = start && state != RUN && !(cancel && state == IDLE);
    last   = cnt == CW'(1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      banderas  <= '0;
      cnt       <= '0;
      dvd       <= '0;
      dvs       <= '0;
      r         <= '0;
    end else begin
      done <= 1'b0;
      if (state == RUN) begin
        if (cancel) begin
          state <= IDLE;
          busy  <= 1'b0;
        end else begin
          r   <= r_nx;
          dvd <= q_nx;
          cnt <= cnt - CW'(1);
          if (last) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= q_nx;
            remainder <= r_nx;
            banderas  <= {1'b0, q_nx == '0, 2'b00};
          end
        end
      end else if (accept) begin
        if (b == '0) begin
          state     <= DONE;
          done      <= 1'b1;
          quotient  <= '1;
          remainder <= a;
          banderas  <= 4'b0001;
        end else begin
          state <= RUN;
          busy  <= 1'b1;
          dvd   <= a;
          dvs   <= b;
          r     <= '0;
          cnt   <= CW'(N);
        end
      end else begin
        state <= IDLE;
      end
    end
  end
endmodule
